// File: rtl/lemmings_dig_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : lemmings_dig_arbiter_if
// Brief    : Bundle of request/status/tool signals between the player-input
//            layer, the lemming FSM array and the dig-tool arbiter.
//            master = request/status side, slave = arbiter side.
// Revision : 1.0 - initial release
// ============================================================================
interface lemmings_dig_arbiter_if #(
  parameter int N    = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 8
);
  logic [N-1:0]    dig_req;
  logic [N-1:0]    digging;
  logic [N-1:0]    dig;
  logic [N-1:0]    grant;
  logic [IDW-1:0]  grant_id;
  logic            busy;
  logic            done;
  logic            abort;
  logic [CNTW-1:0] dig_count;

  modport master (
    output dig_req, digging,
    input  dig, grant, grant_id, busy, done, abort, dig_count
  );

  modport slave (
    input  dig_req, digging,
    output dig, grant, grant_id, busy, done, abort, dig_count
  );
endinterface
`default_nettype wire

// File: rtl/lemmings_dig_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lemmings_dig_arbiter
// Brief    : Round-robin arbiter sharing one dig tool among N lemming FSMs.
//            Grants one lemming, drives its dig input until digging starts,
//            holds the grant through the dig, then cools down before the
//            next arbitration.
//            Optional macro LEMMINGS_DIG_TIMEOUT_EN: abort a grant whose
//            owner never starts digging within TIMEOUT cycles.
// Revision : 1.0 - initial release
// ============================================================================
module lemmings_dig_arbiter #(
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int COOL    = 3,
  parameter int TIMEOUT = 8,
  parameter int CNTW    = 8
) (
  input  logic                  clk,
  input  logic                  areset,
  lemmings_dig_arbiter_if.slave bus
);

  // Timer serves both the WAIT timeout and the cooldown, so size for the longer.
  localparam int MAXT  = (TIMEOUT > COOL) ? TIMEOUT : COOL;
  localparam int TMR_W = $clog2(MAXT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACTIVE = 2'd2,
    S_COOL   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [IDW-1:0]  gid_q,   gid_d;
  logic [IDW-1:0]  last_q,  last_d;
  logic [TMR_W-1:0] tmr_q,  tmr_d;
  logic [CNTW-1:0] cnt_q,   cnt_d;
  logic            done_q,  done_d;
  logic            abort_q, abort_d;

  logic            pick_valid;
  logic [IDW-1:0]  pick_id;
  logic            w_owner_digging;

  // Round-robin pick: lowest requester above last, else lowest requester overall.
  always_comb begin : p_pick
    logic           hi_v;
    logic [IDW-1:0] hi_id;
    logic [IDW-1:0] lo_id;
    hi_v       = 1'b0;
    hi_id      = '0;
    lo_id      = '0;
    pick_valid = |bus.dig_req;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.dig_req[i]) begin
        lo_id = IDW'(i);
        if (IDW'(i) > last_q) begin
          hi_v  = 1'b1;
          hi_id = IDW'(i);
        end
      end
    end
    pick_id = hi_v ? hi_id : lo_id;
  end

  // Only the current owner's digging status matters.
  assign w_owner_digging = |(bus.digging & grant_q);

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      gid_q   <= '0;
      last_q  <= IDW'(N - 1);
      tmr_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  // Next-state logic: arbitrate, wait for dig start, hold, cool down.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gid_d   = gid_q;
    last_d  = last_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          for (int i = 0; i < N; i++) begin
            grant_d[i] = (IDW'(i) == pick_id);
          end
          gid_d   = pick_id;
          last_d  = pick_id;
          tmr_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_owner_digging) begin
          state_d = S_ACTIVE;
          if (cnt_q != {CNTW{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`ifdef LEMMINGS_DIG_TIMEOUT_EN
        else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
          state_d = S_COOL;
          tmr_d   = '0;
          abort_d = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
`endif
      end
      S_ACTIVE: begin
        if (!w_owner_digging) begin
          state_d = S_COOL;
          tmr_d   = '0;
          done_d  = 1'b1;
        end
      end
      S_COOL: begin
        if (tmr_q == TMR_W'(COOL - 1)) begin
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from state and registers only.
  assign bus.dig       = (state_q == S_WAIT) ? grant_q : '0;
  assign bus.grant     = (state_q == S_WAIT || state_q == S_ACTIVE) ? grant_q : '0;
  assign bus.grant_id  = gid_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.dig_count = cnt_q;
`ifdef LEMMINGS_DIG_TIMEOUT_EN
  assign bus.abort     = abort_q;
`else
  assign bus.abort     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lemmings_dig_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lemmings_dig_arbiter
// Brief    : Self-checking bench for lemmings_dig_arbiter: directed table,
//            hand-written corner sequences and random traffic against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lemmings_dig_arbiter;
  localparam int N       = 4;
  localparam int IDW     = 2;
  localparam int COOL    = 3;
  localparam int TIMEOUT = 8;
  localparam int CNTW    = 8;
  localparam int CMAX    = (1 << CNTW) - 1;

  logic clk;
  logic areset;
  int   n_vec;
  int   n_miss;

  lemmings_dig_arbiter_if #(.N(N), .IDW(IDW), .CNTW(CNTW)) bus ();

  lemmings_dig_arbiter #(
    .N(N), .IDW(IDW), .COOL(COOL), .TIMEOUT(TIMEOUT), .CNTW(CNTW)
  ) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 waiting for dig start, 2 digging, 3 cooling.
  int m_phase, m_owner, m_last, m_gid, m_waited, m_cool_left, m_count;
  bit m_done, m_abort;

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_last = N - 1; m_gid = 0;
    m_waited = 0; m_cool_left = 0; m_count = 0; m_done = 0; m_abort = 0;
  endtask

  task automatic model_step(input logic [N-1:0] req, input logic [N-1:0] dg);
    bit found;
    bit owner_dig;
    m_done  = 0;
    m_abort = 0;
    owner_dig = ((int'(dg) >> m_owner) & 1) == 1;
    case (m_phase)
      0: if (req != 0) begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (!found && ((int'(req) >> c) & 1) == 1) begin
            found = 1;
            m_owner = c;
          end
        end
        m_last = m_owner; m_gid = m_owner; m_waited = 0; m_phase = 1;
      end
      1: if (owner_dig) begin
        m_phase = 2;
        if (m_count < CMAX) m_count = m_count + 1;
      end else begin
        m_waited = m_waited + 1;
`ifdef LEMMINGS_DIG_TIMEOUT_EN
        if (m_waited == TIMEOUT) begin
          m_phase = 3; m_cool_left = COOL; m_abort = 1;
        end
`endif
      end
      2: if (!owner_dig) begin
        m_phase = 3; m_cool_left = COOL; m_done = 1;
      end
      default: begin
        m_cool_left = m_cool_left - 1;
        if (m_cool_left == 0) m_phase = 0;
      end
    endcase
  endtask

  function automatic logic [20:0] model_pack();
    logic [3:0] oh;
    oh = 4'(1 << m_owner);
    return {(m_phase == 1) ? oh : 4'b0,
            (m_phase == 1 || m_phase == 2) ? oh : 4'b0,
            2'(m_gid), m_phase != 0, m_done, m_abort, 8'(m_count)};
  endfunction

  function automatic logic [20:0] dut_pack();
    return {bus.dig, bus.grant, bus.grant_id, bus.busy, bus.done, bus.abort, bus.dig_count};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, let the edge happen, update model, compare.
  task automatic cycle(input logic [3:0] req, input logic [3:0] dg);
    bus.dig_req = req;
    bus.digging = dg;
    @(posedge clk);
    model_step(req, dg);
    #1;
    check("model", 32'(dut_pack()), 32'(model_pack()));
  endtask

  task automatic do_reset();
    areset = 1'b0;
    bus.dig_req = '0;
    bus.digging = '0;
    model_reset();
    @(posedge clk);
    #1;
    check("reset_state", 32'(dut_pack()), 32'd0);
    areset = 1'b1;
  endtask

  // Full dig from IDLE with all requests held; checks arbitration order.
  task automatic run_dig(input logic [3:0] req, input int exp_id);
    logic [3:0] e;
    e = 4'(1 << exp_id);
    cycle(req, 4'b0);
    check("rr_grant", 32'(bus.grant), 32'(e));
    check("rr_gid", 32'(bus.grant_id), 32'(exp_id));
    cycle(req, 4'b0);
    cycle(req, 4'hF);
    cycle(req, 4'hF);
    cycle(req, 4'b0);
    check("rr_done", 32'(bus.done), 32'd1);
    for (int i = 0; i < COOL; i++) cycle(req, 4'b0);
    check("rr_idle", 32'(bus.busy), 32'd0);
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] dg;
    logic [3:0] dig;
    logic [3:0] grant;
    logic [1:0] gid;
    logic       busy;
    logic       done;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int hi;
    bit ab;
    logic [7:0] cnt0;
    n_vec = 0;
    n_miss = 0;
    areset = 1'b0;
    bus.dig_req = '0;
    bus.digging = '0;

    //           req      dg       dig      grant    gid  busy done cnt
    tbl[0] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 8'd0};
    tbl[1] = '{4'b0001, 4'b0000, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0, 8'd0};
    tbl[2] = '{4'b0001, 4'b0000, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0, 8'd0};
    tbl[3] = '{4'b0000, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, 8'd1};
    tbl[4] = '{4'b0000, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, 8'd1};
    tbl[5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b1, 8'd1};
    tbl[6] = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 8'd1};
    tbl[7] = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 8'd1};
    tbl[8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 8'd1};

    #12;
    do_reset();

    // Directed first dig, request dropped during cooldown is lost.
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].req, tbl[i].dg);
      check($sformatf("tbl%0d", i), 32'(dut_pack()),
            32'({tbl[i].dig, tbl[i].grant, tbl[i].gid, tbl[i].busy, tbl[i].done, 1'b0, tbl[i].cnt}));
    end

    // Round robin from reset with all lemmings requesting, then wrap.
    do_reset();
    run_dig(4'hF, 0);
    run_dig(4'hF, 1);
    run_dig(4'hF, 2);
    run_dig(4'hF, 3);
    run_dig(4'hF, 0);

    // Owner never starts digging.
    cnt0 = bus.dig_count;
    hi = 0;
    ab = 0;
    cycle(4'b0010, 4'b0);
    if (bus.dig != 0) hi++;
    for (int i = 0; i < 12; i++) begin
      cycle(4'b0, 4'b0);
      if (bus.dig != 0) hi++;
      if (bus.abort) ab = 1;
    end
`ifdef LEMMINGS_DIG_TIMEOUT_EN
    check("to_dig_width", 32'(hi), 32'(TIMEOUT));
    check("to_abort", 32'(ab), 32'd1);
    check("to_count", 32'(bus.dig_count), 32'(cnt0));
    check("to_idle", 32'(bus.busy), 32'd0);
`else
    check("nto_dig_held", 32'(hi), 32'd13);
    check("nto_abort", 32'(ab), 32'd0);
    check("nto_count", 32'(bus.dig_count), 32'(cnt0));
    cycle(4'b0, 4'b0010);
    cycle(4'b0, 4'b0);
    for (int i = 0; i < COOL; i++) cycle(4'b0, 4'b0);
`endif

    // Reset while digging: immediate clear, priority pointer back to lemming 0.
    cycle(4'b0001, 4'b0);
    cycle(4'b0, 4'b0001);
    check("pre_rst_active", 32'(bus.grant), 32'h1);
    #2;
    areset = 1'b0;
    #1;
    check("async_rst", 32'({bus.dig, bus.grant, bus.busy, bus.done, bus.abort}), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    areset = 1'b1;
    cycle(4'b0101, 4'b0);
    check("rst_last", 32'(bus.grant), 32'h1);
    cycle(4'b0, 4'b0);
    cycle(4'b0, 4'b0001);
    cycle(4'b0, 4'b0);
    for (int i = 0; i < COOL; i++) cycle(4'b0, 4'b0);

    // Counter saturation.
    for (int d = 0; d < CMAX + 5; d++) begin
      cycle(4'($urandom_range(1, 15)), 4'b0);
      cycle(4'b0, 4'hF);
      cycle(4'b0, 4'b0);
      for (int i = 0; i < COOL; i++) cycle(4'b0, 4'b0);
    end
    check("saturate", 32'(bus.dig_count), 32'(CMAX));

    // Random traffic, including non-owner digging bits.
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      logic [3:0] r;
      r = ($urandom_range(0, 9) < 3) ? 4'b0 : 4'($urandom_range(0, 15));
      cycle(r, 4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/lemmings_dig_arbiter.md
# lemmings_dig_arbiter

Round-robin arbiter sharing a single dig tool among N Lemmings walker FSMs. Player dig requests arrive per lemming. The arbiter grants the tool to one lemming at a time and drives that lemming's `dig` input until its `digging` status confirms the dig has started. It then holds the grant for the whole dig and enforces a cooldown before re-arbitrating. It sits between the player-input layer and the array of Lemmings FSM instances.

## Interface
- `N`, 4: number of lemmings (2..8).
- `IDW`, 2: width of `grant_id`; must be at least clog2(N).
- `COOL`, 3: cooldown length in cycles, at least 1.
- `TIMEOUT`, 8: maximum cycles `dig` is held waiting for `digging`, at least 2.
- `CNTW`, 8: width of the completed-dig counter.
- `clk` input 1: rising-edge clock.
- `areset` input 1: asynchronous, active-low reset.
- `dig_req` input N: level requests, bit i = lemming i wants to dig.
- `digging` input N: `digging` outputs of the lemming FSMs.
- `dig` output N: `dig` inputs to the lemming FSMs; at most one bit high.
- `grant` output N: one-hot, marks the current tool owner; 0 when idle or in cooldown.
- `grant_id` output IDW: index of the most recent grant; held through IDLE.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse, owner's dig finished.
- `abort` output 1: one-cycle pulse, owner never started digging.
- `dig_count` output CNTW: count of digs started; saturates at all-ones.

## Operation
- States: IDLE, WAIT, ACTIVE, COOL.
- IDLE:
  - If `dig_req` is nonzero, pick the first set bit searching from (`last`+1) mod N, wrapping.
  - Register `grant` and `grant_id`, set `last` = pick, clear `tmr`, go to WAIT.
  - If `dig_req` is zero, stay in IDLE.
- WAIT:
  - `dig` = `grant`.
  - If `digging[g]` = 1, go to ACTIVE and increment `dig_count` (saturating).
  - Else, if `tmr` == TIMEOUT-1, go to COOL and set the abort flag.
  - Else, `tmr` += 1.
  - `digging[g]` takes priority over timeout in the same cycle.
- ACTIVE:
  - `dig` = 0 and `grant` is held.
  - When `digging[g]` = 0 (the lemming fell through), go to COOL and set the done flag.
- COOL:
  - `grant` = 0 and `dig` = 0.
  - `tmr` counts COOL cycles, then the block returns to IDLE.
  - `done`/`abort` are high only in the first COOL cycle.
- Requests are not latched. A request dropped before arbitration is lost. Requests from other lemmings during WAIT/ACTIVE/COOL are ignored until IDLE.
- `digging` bits of non-owners are ignored.
- Reset values:
  - State = IDLE.
  - `last` = N-1, so lemming 0 has first priority.
  - `dig`, `grant`, `grant_id`, `busy`, `done`, `abort`, `dig_count`, `tmr` = 0.
- Reset mid-operation: all outputs clear immediately (asynchronously) and no `done`/`abort` is emitted.

## Timing
- `dig_req` sampled at edge 0 → `dig[g]`, `grant[g]`, `busy` high in cycle 1.
- Lemming FSM samples `dig` at edge 1 → `digging[g]` high in cycle 2 → ACTIVE from cycle 3. Nominal `dig` width is 2 cycles.
- `dig` is held for at most TIMEOUT cycles, which covers a lemming that is falling or landing when granted.
- COOL lasts exactly COOL cycles; the earliest next grant is visible COOL+1 cycles after the ACTIVE exit edge.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.

## Configuration
- `LEMMINGS_DIG_TIMEOUT_EN` defined: WAIT times out as described and `abort` is functional.
- `LEMMINGS_DIG_TIMEOUT_EN` undefined:
  - WAIT holds `dig` indefinitely until `digging[g]`.
  - `abort` is tied to 0.
  - `TIMEOUT` is unused and `tmr` is used only by COOL.

## Test plan
- Reset, then `dig_req`=0001 at edge 0 → `dig`=0001 in cycles 1-2; `digging[0]` high in cycle 2 → ACTIVE. `dig_count`=1.
- In ACTIVE, drop `digging[0]` → `done` pulse in the first COOL cycle. `busy` high for 3 COOL cycles, then IDLE.
- `dig_req`=1111 held across four arbitrations → grants in order 0,1,2,3; `grant_id` 0,1,2,3; then wraps to 0.
- Timeout enabled, owner's `digging` stays 0 → `dig` high for exactly 8 cycles, `abort` pulse, `dig_count` unchanged.
- Assert `areset` low in ACTIVE → `dig`/`grant`/`busy`=0 immediately. After release, `dig_req`=0100 → grant lemming 2 (`last` reset to 3).
- `CNTW`=2: complete 5 digs → `dig_count` saturates at 3.
